ula_b_operand_stage: RTL

ULA_B_OPERAND_STAGE -- requirements
Module: ula_b_operand_stage

---
 rtl/ula_pkg.sv | 20 ++
 rtl/ula_b_select.sv | 48 ++++
 rtl/ula_b_operand_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared encodings for the ULA operand B stage: mode codes, skid-buffer states,
// and the default constant presented on selector code 0.
package ula_pkg;

   localparam int DEF_CONST_VAL = 4;

   typedef enum logic [1:0] {
      MODE_PASS     = 2'b00,
      MODE_SEXT     = 2'b01,
      MODE_SEXT_SL2 = 2'b10,
      MODE_ZEXT     = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_FULL  = 2'b10
   } buf_state_e;

endpackage

// File: rtl/ula_b_select.sv
// Combinational operand B selection: constant / channel / error, then the
// 16-bit immediate style transform chosen by mode.
module ula_b_select
   import ula_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_IN    = 4,
   parameter int CONST_VAL = DEF_CONST_VAL,
   parameter int SEL_W     = 4
) (
   input  logic [SEL_W-1:0]        selector,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [1:0]              mode,
   output logic [WIDTH-1:0]        operand,
   output logic                    sel_err
);

   logic [WIDTH-1:0] sel_val;
   logic [WIDTH-1:0] sext_val;

   // Any code not matched below is out of range and yields zero with sel_err.
   always_comb begin
      sel_val = '0;
      sel_err = 1'b1;
      if (selector == '0) begin
         sel_val = WIDTH'(CONST_VAL);
         sel_err = 1'b0;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (selector == SEL_W'(i + 1)) begin
            sel_val = data_in[i*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

   assign sext_val = {{(WIDTH-16){sel_val[15]}}, sel_val[15:0]};

   always_comb begin
      case (mode)
         MODE_SEXT:     operand = sext_val;
         MODE_SEXT_SL2: operand = {sext_val[WIDTH-3:0], 2'b00};
         MODE_ZEXT:     operand = {{(WIDTH-16){1'b0}}, sel_val[15:0]};
         default:       operand = sel_val;
      endcase
   end

endmodule

// File: rtl/ula_b_operand_stage.sv
// Operand B stage: select/transform, then a 2-entry skid buffer so in_ready is
// a flop and never depends combinationally on out_ready.
module ula_b_operand_stage
   import ula_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_IN    = 4,
   parameter int CONST_VAL = DEF_CONST_VAL,
   parameter int SEL_W     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        selector,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [1:0]              mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        operand_out,
   output logic                    sel_err
);

   buf_state_e       state, state_nxt;
   logic [WIDTH-1:0] sel_operand;
   logic             sel_operand_err;
   logic [WIDTH-1:0] out_q, skid_q;
   logic             out_err_q, skid_err_q;
   logic             in_ready_q, out_valid_q;
   logic             acc, drn;
   logic             ld_out_new, ld_out_skid, ld_skid;

   ula_b_select #(
      .WIDTH     (WIDTH),
      .NUM_IN    (NUM_IN),
      .CONST_VAL (CONST_VAL),
      .SEL_W     (SEL_W)
   ) u_sel (
      .selector (selector),
      .data_in  (data_in),
      .mode     (mode),
      .operand  (sel_operand),
      .sel_err  (sel_operand_err)
   );

   assign acc = in_valid && in_ready_q;
   assign drn = out_valid_q && out_ready;

   always_comb begin
      state_nxt   = state;
      ld_out_new  = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
      case (state)
         BUF_EMPTY: if (acc) begin
            state_nxt  = BUF_ONE;
            ld_out_new = 1'b1;
         end
         BUF_ONE: begin
            if (acc && drn) begin
               ld_out_new = 1'b1;
            end else if (acc) begin
               state_nxt = BUF_FULL;
               ld_skid   = 1'b1;
            end else if (drn) begin
               state_nxt = BUF_EMPTY;
            end
         end
         BUF_FULL: if (drn) begin
            state_nxt   = BUF_ONE;
            ld_out_skid = 1'b1;
         end
         default: state_nxt = BUF_EMPTY;
      endcase
   end

   // Handshake flags are re-registered from the next state so both are flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= BUF_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_err_q   <= 1'b0;
         skid_q      <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= (state_nxt != BUF_FULL);
         out_valid_q <= (state_nxt != BUF_EMPTY);
         if (ld_out_new) begin
            out_q     <= sel_operand;
            out_err_q <= sel_operand_err;
         end else if (ld_out_skid) begin
            out_q     <= skid_q;
            out_err_q <= skid_err_q;
         end
         if (ld_skid) begin
            skid_q     <= sel_operand;
            skid_err_q <= sel_operand_err;
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign operand_out = out_q;
   assign sel_err     = out_err_q;

endmodule
